// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
// Round-robin scheduler sharing one uart_send byte transmitter between three
// report sources (0 = temperature, 1 = time, 2 = alarm). Each source request
// snapshots its payload into a shadow register. The FSM frames the winner
// into a packet and feeds it byte by byte through the uart_en/uart_tx_busy
// handshake.
//
// Optional feature: define UART_ARB_CHECKSUM_EN to append a modulo-256
// checksum byte (type byte + data bytes, header excluded) to every packet.
//
// Parameters:
//   BUSY_WAIT  cycles to wait for uart_tx_busy to rise before the byte is
//              treated as sent
//   HEADER     first byte of every packet
// Ports:
//   sys_clk, sys_rst_n         clock, asynchronous active-low reset
//   req_temp,  temp_data       temperature request + payload
//   req_time,  time_hour/min/sec   time request + payload
//   req_alarm, alarm_hour/min  alarm request + payload
//   uart_tx_busy               busy flag from uart_send
//   uart_en, uart_din          one-cycle byte strobe and byte to uart_send
//   grant_id                   source in flight (3 = none)
//   arb_busy                   high whenever the FSM is not idle
//   done                       one-cycle pulse per source on packet completion
//   overwrite                  one-cycle pulse when an unsent payload is replaced
module uart_tx_arbiter #(
  parameter int          BUSY_WAIT = 16,
  parameter logic [7:0]  HEADER    = 8'hA5
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       req_temp,
  input  logic [7:0] temp_data,
  input  logic       req_time,
  input  logic [7:0] time_hour,
  input  logic [7:0] time_min,
  input  logic [7:0] time_sec,
  input  logic       req_alarm,
  input  logic [7:0] alarm_hour,
  input  logic [7:0] alarm_min,
  input  logic       uart_tx_busy,
  output logic       uart_en,
  output logic [7:0] uart_din,
  output logic [1:0] grant_id,
  output logic       arb_busy,
  output logic [2:0] done,
  output logic [2:0] overwrite
);

  typedef enum logic [2:0] {IDLE, LOAD, SEND, WAIT_HI, WAIT_LO, DONE} state_t;

  localparam int             CW        = (BUSY_WAIT > 1) ? $clog2(BUSY_WAIT) : 1;
  localparam logic [CW-1:0]  WAIT_LAST = CW'(BUSY_WAIT - 1);

  state_t        state_reg, state_next;
  logic [2:0]    pending_reg;
  logic [2:0]    overwrite_reg;
  logic [7:0]    temp_sh_reg, hour_sh_reg, min_sh_reg, sec_sh_reg;
  logic [7:0]    ahour_sh_reg, amin_sh_reg;
  logic [1:0]    last_grant_reg, grant_reg;
  logic [7:0]    pkt_reg [0:5];
  logic [2:0]    idx_reg, last_idx_reg;
  logic [CW-1:0] wait_cnt_reg;

  logic [2:0]    req;
  logic          load;
  logic [1:0]    c0, c1, c2, win;
  logic [7:0]    load_bytes [0:5];
  logic [2:0]    load_last;

  assign req  = {req_alarm, req_time, req_temp};
  assign load = (state_reg == LOAD);

`ifdef UART_ARB_CHECKSUM_EN
  localparam logic [2:0] CHK_LEN = 3'd1;
  logic [7:0] chk_temp, chk_time, chk_alarm;
  assign chk_temp  = 8'h01 + temp_sh_reg;
  assign chk_time  = 8'h02 + hour_sh_reg + min_sh_reg + sec_sh_reg;
  assign chk_alarm = 8'h03 + ahour_sh_reg + amin_sh_reg;
`else
  localparam logic [2:0] CHK_LEN = 3'd0;
`endif

  // Round-robin search order starts one past the last granted source.
  always_comb begin
    c0 = (last_grant_reg == 2'd2) ? 2'd0 : last_grant_reg + 2'd1;
    c1 = (c0 == 2'd2) ? 2'd0 : c0 + 2'd1;
    c2 = (c1 == 2'd2) ? 2'd0 : c1 + 2'd1;
    if (pending_reg[c0])      win = c0;
    else if (pending_reg[c1]) win = c1;
    else                      win = c2;
  end

  // Packet image of the current winner, built from its shadow registers.
  always_comb begin
    for (int i = 0; i < 6; i++) load_bytes[i] = 8'h00;
    load_bytes[0] = HEADER;
    load_last     = 3'd0;
    case (win)
      2'd0: begin
        load_bytes[1] = 8'h01;
        load_bytes[2] = temp_sh_reg;
`ifdef UART_ARB_CHECKSUM_EN
        load_bytes[3] = chk_temp;
`endif
        load_last = 3'd2 + CHK_LEN;
      end
      2'd1: begin
        load_bytes[1] = 8'h02;
        load_bytes[2] = hour_sh_reg;
        load_bytes[3] = min_sh_reg;
        load_bytes[4] = sec_sh_reg;
`ifdef UART_ARB_CHECKSUM_EN
        load_bytes[5] = chk_time;
`endif
        load_last = 3'd4 + CHK_LEN;
      end
      default: begin
        load_bytes[1] = 8'h03;
        load_bytes[2] = ahour_sh_reg;
        load_bytes[3] = amin_sh_reg;
`ifdef UART_ARB_CHECKSUM_EN
        load_bytes[4] = chk_alarm;
`endif
        load_last = 3'd3 + CHK_LEN;
      end
    endcase
  end

  // Pending bits and shadows. A request in the LOAD cycle of its own source
  // wins over the clear: the packet takes the old shadow, the new payload
  // stays pending. That payload was being sent, so it is not an overwrite.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      pending_reg   <= 3'b000;
      overwrite_reg <= 3'b000;
      temp_sh_reg   <= 8'h00;
      hour_sh_reg   <= 8'h00;
      min_sh_reg    <= 8'h00;
      sec_sh_reg    <= 8'h00;
      ahour_sh_reg  <= 8'h00;
      amin_sh_reg   <= 8'h00;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (req[i])                          pending_reg[i] <= 1'b1;
        else if (load && (win == 2'(i)))     pending_reg[i] <= 1'b0;
        overwrite_reg[i] <= req[i] && pending_reg[i] && !(load && (win == 2'(i)));
      end
      if (req_temp) temp_sh_reg <= temp_data;
      if (req_time) begin
        hour_sh_reg <= time_hour;
        min_sh_reg  <= time_min;
        sec_sh_reg  <= time_sec;
      end
      if (req_alarm) begin
        ahour_sh_reg <= alarm_hour;
        amin_sh_reg  <= alarm_min;
      end
    end
  end

  // Packet buffer, byte index, grant bookkeeping and busy-wait counter.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      for (int i = 0; i < 6; i++) pkt_reg[i] <= 8'h00;
      idx_reg        <= 3'd0;
      last_idx_reg   <= 3'd0;
      last_grant_reg <= 2'd2;
      grant_reg      <= 2'd3;
      wait_cnt_reg   <= '0;
    end else begin
      case (state_reg)
        LOAD: begin
          for (int i = 0; i < 6; i++) pkt_reg[i] <= load_bytes[i];
          idx_reg        <= 3'd0;
          last_idx_reg   <= load_last;
          last_grant_reg <= win;
          grant_reg      <= win;
        end
        WAIT_LO: begin
          if (!uart_tx_busy && (idx_reg != last_idx_reg)) idx_reg <= idx_reg + 3'd1;
        end
        DONE:    grant_reg <= 2'd3;
        default: ;
      endcase
      wait_cnt_reg <= (state_reg == WAIT_HI) ? wait_cnt_reg + CW'(1) : '0;
    end
  end

  // FSM state register.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state_reg <= IDLE;
    else            state_reg <= state_next;
  end

  // FSM next state. DONE goes straight to LOAD for back-to-back packets.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (|pending_reg) state_next = LOAD;
      LOAD:    state_next = SEND;
      SEND:    state_next = WAIT_HI;
      WAIT_HI: if (uart_tx_busy || (wait_cnt_reg == WAIT_LAST)) state_next = WAIT_LO;
      WAIT_LO: if (!uart_tx_busy) state_next = (idx_reg == last_idx_reg) ? DONE : SEND;
      DONE:    state_next = (|pending_reg) ? LOAD : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // FSM outputs. uart_din holds the current byte for the whole byte period.
  always_comb begin
    uart_en   = (state_reg == SEND);
    uart_din  = 8'h00;
    if ((state_reg == SEND) || (state_reg == WAIT_HI) || (state_reg == WAIT_LO))
      uart_din = pkt_reg[idx_reg];
    arb_busy  = (state_reg != IDLE);
    done      = (state_reg == DONE) ? (3'b001 << grant_reg) : 3'b000;
    grant_id  = grant_reg;
    overwrite = overwrite_reg;
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Testbench for uart_tx_arbiter: table of single-source packets, hand-written
// corner sequences and randomized multi-source rounds against a packet-level
// reference model.
module tb_uart_tx_arbiter;

  localparam logic [7:0] HDR = 8'hA5;
`ifdef UART_ARB_CHECKSUM_EN
  localparam int CHK = 1;
`else
  localparam int CHK = 0;
`endif

  logic       sys_clk = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic       req_temp = 1'b0, req_time = 1'b0, req_alarm = 1'b0;
  logic [7:0] temp_data = 8'h00, time_hour = 8'h00, time_min = 8'h00, time_sec = 8'h00;
  logic [7:0] alarm_hour = 8'h00, alarm_min = 8'h00;
  logic       uart_tx_busy = 1'b0;
  logic       uart_en;
  logic [7:0] uart_din;
  logic [1:0] grant_id;
  logic       arb_busy;
  logic [2:0] done;
  logic [2:0] overwrite;

  uart_tx_arbiter #(.BUSY_WAIT(16), .HEADER(8'hA5)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .req_temp(req_temp), .temp_data(temp_data),
    .req_time(req_time), .time_hour(time_hour), .time_min(time_min), .time_sec(time_sec),
    .req_alarm(req_alarm), .alarm_hour(alarm_hour), .alarm_min(alarm_min),
    .uart_tx_busy(uart_tx_busy),
    .uart_en(uart_en), .uart_din(uart_din), .grant_id(grant_id),
    .arb_busy(arb_busy), .done(done), .overwrite(overwrite)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic [2:0] mask;
    logic [7:0] t, h, m, s, ah, am;
  } req_t;

  typedef struct {
    int          src;
    logic [7:0]  d0, d1, d2;
    int          busy;
    int          len;      // length with checksum byte
    logic [47:0] b;        // expected bytes, first byte in [47:40]
  } vec_t;

  int tests_run = 0;
  int tests_failed = 0;

  // UART model state and logs
  int         cyc = 0;
  int         busy_len = 20;
  int         busy_cnt = 0;
  logic       busy_force = 1'b0;
  logic [7:0] rx_q[$];
  int         rx_cyc[$];
  logic [1:0] rx_gnt[$];
  logic [2:0] done_q[$];
  int         ow_seen[3];

  // expectations
  logic [7:0] exp_q[$];
  logic [2:0] exp_done[$];
  int         exp_ow[3];
  int         model_last = 2;

  always @(negedge sys_clk) begin
    cyc++;
    if (!sys_rst_n) busy_cnt = 0;
    else if (uart_en) begin
      rx_q.push_back(uart_din);
      rx_cyc.push_back(cyc);
      rx_gnt.push_back(grant_id);
      busy_cnt = busy_len;
    end else if (busy_cnt > 0) busy_cnt--;
    uart_tx_busy = busy_force || (busy_cnt > 0);
    if (done != 3'b000) done_q.push_back(done);
    for (int i = 0; i < 3; i++) if (overwrite[i]) ow_seen[i]++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_logs();
    rx_q.delete(); rx_cyc.delete(); rx_gnt.delete(); done_q.delete();
    exp_q.delete(); exp_done.delete();
    for (int i = 0; i < 3; i++) begin ow_seen[i] = 0; exp_ow[i] = 0; end
  endtask

  task automatic issue(input req_t r);
    req_temp  = r.mask[0]; req_time = r.mask[1]; req_alarm = r.mask[2];
    temp_data = r.t; time_hour = r.h; time_min = r.m; time_sec = r.s;
    alarm_hour = r.ah; alarm_min = r.am;
    @(negedge sys_clk);
    req_temp = 1'b0; req_time = 1'b0; req_alarm = 1'b0;
  endtask

  task automatic wait_quiet(input string name, input int budget);
    int q = 0;
    int n = 0;
    while (q < 3 && n < budget) begin
      @(negedge sys_clk);
      n++;
      q = arb_busy ? 0 : q + 1;
    end
    check({name, "_idle_timeout"}, 32'(q >= 3), 32'd1);
  endtask

  task automatic wait_bytes(input string name, input int cnt, input int budget);
    int n = 0;
    while (rx_q.size() < cnt && n < budget) begin
      @(negedge sys_clk);
      n++;
    end
    check({name, "_byte_timeout"}, 32'(rx_q.size() >= cnt), 32'd1);
  endtask

  function automatic int rr(input logic [2:0] pend, input int last);
    for (int k = 1; k <= 3; k++) begin
      int c = (last + k) % 3;
      if (pend[c]) return c;
    end
    return -1;
  endfunction

  // Expected packet: header, type, data bytes, optional byte-sum checksum.
  task automatic append_pkt(input int src, input req_t r);
    logic [7:0] d[$];
    logic [7:0] sum = 8'h00;
    d.push_back(8'(src + 1));
    case (src)
      0:       d.push_back(r.t);
      1:       begin d.push_back(r.h); d.push_back(r.m); d.push_back(r.s); end
      default: begin d.push_back(r.ah); d.push_back(r.am); end
    endcase
    exp_q.push_back(HDR);
    foreach (d[i]) begin
      exp_q.push_back(d[i]);
      sum = sum + d[i];
    end
    if (CHK == 1) exp_q.push_back(sum);
    exp_done.push_back(3'(1 << src));
  endtask

  task automatic compare_logs(input string name);
    int n;
    check({name, "_nbytes"}, 32'(rx_q.size()), 32'(exp_q.size()));
    n = (rx_q.size() < exp_q.size()) ? rx_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      check($sformatf("%s_byte%0d", name, i), 32'(rx_q[i]), 32'(exp_q[i]));
    check({name, "_ndone"}, 32'(done_q.size()), 32'(exp_done.size()));
    n = (done_q.size() < exp_done.size()) ? done_q.size() : exp_done.size();
    for (int i = 0; i < n; i++)
      check($sformatf("%s_done%0d", name, i), 32'(done_q[i]), 32'(exp_done[i]));
    for (int i = 0; i < 3; i++)
      check($sformatf("%s_overwrite%0d", name, i), 32'(ow_seen[i]), 32'(exp_ow[i]));
    check({name, "_grant_idle"}, 32'(grant_id), 32'd3);
    $display("[TB] %s: %0d bytes, %0d packets", name, rx_q.size(), done_q.size());
  endtask

  // r1 from idle; r2 and r3 arrive while the first packet is on the wire.
  task automatic run_round(input string name, input req_t r1, input req_t r2,
                           input req_t r3, input int bl);
    req_t       snap[3];
    logic [2:0] pend;
    int         w;
    busy_len = bl;
    clear_logs();
    issue(r1);
    pend = r1.mask;
    for (int i = 0; i < 3; i++) if (r1.mask[i]) snap[i] = r1;
    w = rr(pend, model_last);
    append_pkt(w, snap[w]);
    pend[w] = 1'b0;
    model_last = w;
    wait_bytes(name, 1, 400);
    issue(r2);
    for (int i = 0; i < 3; i++) if (r2.mask[i]) begin
      if (pend[i]) exp_ow[i]++;
      snap[i] = r2; pend[i] = 1'b1;
    end
    @(negedge sys_clk);
    issue(r3);
    for (int i = 0; i < 3; i++) if (r3.mask[i]) begin
      if (pend[i]) exp_ow[i]++;
      snap[i] = r3; pend[i] = 1'b1;
    end
    while (pend != 3'b000) begin
      w = rr(pend, model_last);
      append_pkt(w, snap[w]);
      pend[w] = 1'b0;
      model_last = w;
    end
    wait_quiet(name, 20000);
    compare_logs(name);
  endtask

  function automatic req_t mk(input logic [2:0] mask, input logic [7:0] t,
                              input logic [7:0] h, input logic [7:0] m, input logic [7:0] s,
                              input logic [7:0] ah, input logic [7:0] am);
    req_t r;
    r.mask = mask; r.t = t; r.h = h; r.m = m; r.s = s; r.ah = ah; r.am = am;
    return r;
  endfunction

  function automatic req_t rnd_req(input logic [2:0] mask);
    return mk(mask, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
              8'($urandom), 8'($urandom));
  endfunction

  vec_t vecs[6];
  req_t none;

  initial begin
    none = mk(3'b000, 0, 0, 0, 0, 0, 0);
    vecs[0] = '{0, 8'h19, 8'h00, 8'h00, 20, 4, {8'hA5, 8'h01, 8'h19, 8'h1A, 8'h00, 8'h00}};
    vecs[1] = '{1, 8'h0C, 8'h22, 8'h38, 3,  6, {8'hA5, 8'h02, 8'h0C, 8'h22, 8'h38, 8'h68}};
    vecs[2] = '{2, 8'h07, 8'h1E, 8'h00, 1,  5, {8'hA5, 8'h03, 8'h07, 8'h1E, 8'h28, 8'h00}};
    vecs[3] = '{0, 8'hFF, 8'h00, 8'h00, 0,  4, {8'hA5, 8'h01, 8'hFF, 8'h00, 8'h00, 8'h00}};
    vecs[4] = '{1, 8'h17, 8'h3B, 8'h3B, 5,  6, {8'hA5, 8'h02, 8'h17, 8'h3B, 8'h3B, 8'h8F}};
    vecs[5] = '{2, 8'hFF, 8'hFF, 8'h00, 2,  5, {8'hA5, 8'h03, 8'hFF, 8'hFF, 8'h01, 8'h00}};

    // Reset values
    repeat (3) @(negedge sys_clk);
    check("rst_uart_en", 32'(uart_en), 32'd0);
    check("rst_uart_din", 32'(uart_din), 32'd0);
    check("rst_grant_id", 32'(grant_id), 32'd3);
    check("rst_arb_busy", 32'(arb_busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_overwrite", 32'(overwrite), 32'd0);
    sys_rst_n = 1'b1;
    model_last = 2;
    @(negedge sys_clk);

    // Request-to-first-byte latency
    clear_logs();
    busy_len = 2;
    req_temp = 1'b1; temp_data = 8'h42;
    @(negedge sys_clk);
    req_temp = 1'b0;
    check("lat_k_en", 32'(uart_en), 32'd0);
    check("lat_k_busy", 32'(arb_busy), 32'd0);
    @(negedge sys_clk);
    check("lat_k1_en", 32'(uart_en), 32'd0);
    check("lat_k1_busy", 32'(arb_busy), 32'd1);
    @(negedge sys_clk);
    check("lat_k2_en", 32'(uart_en), 32'd1);
    check("lat_k2_din", 32'(uart_din), 32'(HDR));
    append_pkt(0, mk(3'b001, 8'h42, 0, 0, 0, 0, 0));
    model_last = 0;
    wait_quiet("latency", 2000);
    compare_logs("latency");

    // Single-source table
    for (int v = 0; v < 6; v++) begin
      string nm;
      req_t  r;
      int    elen;
      nm = $sformatf("vec%0d", v);
      clear_logs();
      busy_len = vecs[v].busy;
      r = mk(3'(1 << vecs[v].src), vecs[v].d0, vecs[v].d0, vecs[v].d1, vecs[v].d2,
             vecs[v].d0, vecs[v].d1);
      issue(r);
      wait_quiet(nm, 2000);
      elen = vecs[v].len - (1 - CHK);
      check({nm, "_len"}, 32'(rx_q.size()), 32'(elen));
      for (int i = 0; i < elen && i < rx_q.size(); i++)
        check($sformatf("%s_byte%0d", nm, i), 32'(rx_q[i]), 32'(vecs[v].b[47-8*i -: 8]));
      if (rx_gnt.size() > 0) check({nm, "_grant"}, 32'(rx_gnt[0]), 32'(vecs[v].src));
      check({nm, "_ndone"}, 32'(done_q.size()), 32'd1);
      if (done_q.size() > 0) check({nm, "_done"}, 32'(done_q[0]), 32'(1 << vecs[v].src));
      check({nm, "_grant_idle"}, 32'(grant_id), 32'd3);
      if (vecs[v].busy == 0)
        for (int i = 1; i < rx_cyc.size(); i++)
          check($sformatf("%s_spacing%0d", nm, i), 32'(rx_cyc[i] - rx_cyc[i-1]), 32'd18);
      model_last = vecs[v].src;
      $display("[TB] %s: src %0d, %0d bytes", nm, vecs[v].src, rx_q.size());
    end

    // Temp overwritten twice while a time packet is in flight
    run_round("overwrite", mk(3'b010, 0, 8'h01, 8'h02, 8'h03, 0, 0),
              mk(3'b001, 8'h10, 0, 0, 0, 0, 0), mk(3'b001, 8'h11, 0, 0, 0, 0, 0), 4);

    // Request on the granted source during its LOAD cycle
    clear_logs();
    busy_len = 2;
    req_temp = 1'b1; temp_data = 8'h10;
    @(negedge sys_clk);
    req_temp = 1'b0;
    @(negedge sys_clk);
    req_temp = 1'b1; temp_data = 8'h11;
    @(negedge sys_clk);
    req_temp = 1'b0;
    append_pkt(0, mk(3'b001, 8'h10, 0, 0, 0, 0, 0));
    append_pkt(0, mk(3'b001, 8'h11, 0, 0, 0, 0, 0));
    model_last = 0;
    wait_quiet("loadreq", 4000);
    compare_logs("loadreq");

    // Busy already high when SEND is entered
    clear_logs();
    busy_len = 0;
    busy_force = 1'b1;
    @(negedge sys_clk);
    issue(mk(3'b001, 8'h33, 0, 0, 0, 0, 0));
    repeat (40) @(negedge sys_clk);
    check("busyhi_held_bytes", 32'(rx_q.size()), 32'd1);
    check("busyhi_arb_busy", 32'(arb_busy), 32'd1);
    busy_force = 1'b0;
    busy_len = 3;
    append_pkt(0, mk(3'b001, 8'h33, 0, 0, 0, 0, 0));
    model_last = 0;
    wait_quiet("busyhi", 4000);
    compare_logs("busyhi");

    // Reset during byte 3 of a time packet, with temp pending
    clear_logs();
    busy_len = 20;
    issue(mk(3'b010, 0, 8'h0C, 8'h22, 8'h38, 0, 0));
    wait_bytes("rstmid", 3, 400);
    issue(mk(3'b001, 8'h55, 0, 0, 0, 0, 0));
    repeat (4) @(negedge sys_clk);
    #2 sys_rst_n = 1'b0;
    #1;
    check("rstmid_uart_en", 32'(uart_en), 32'd0);
    check("rstmid_uart_din", 32'(uart_din), 32'd0);
    check("rstmid_grant_id", 32'(grant_id), 32'd3);
    check("rstmid_arb_busy", 32'(arb_busy), 32'd0);
    check("rstmid_done", 32'(done), 32'd0);
    check("rstmid_overwrite", 32'(overwrite), 32'd0);
    repeat (3) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    model_last = 2;
    repeat (10) @(negedge sys_clk);
    check("rstmid_no_resume", 32'(arb_busy), 32'd0);
    check("rstmid_no_done", 32'(done_q.size()), 32'd0);
    check("rstmid_bytes", 32'(rx_q.size()), 32'd3);

    // All three at once after reset: temp, time, alarm
    run_round("restart", mk(3'b111, 8'h19, 8'h0C, 8'h22, 8'h38, 8'h07, 8'h1E), none, none, 2);
    if (done_q.size() == 3) begin
      check("restart_order0", 32'(done_q[0]), 32'd1);
      check("restart_order1", 32'(done_q[1]), 32'd2);
      check("restart_order2", 32'(done_q[2]), 32'd4);
    end else check("restart_order_count", 32'(done_q.size()), 32'd3);

    // Randomized rounds
    for (int k = 0; k < 25; k++) begin
      req_t r1, r2, r3;
      r1 = rnd_req(3'($urandom_range(1, 7)));
      r2 = rnd_req(3'($urandom_range(0, 7)));
      r3 = rnd_req(($urandom_range(0, 1) == 1) ? 3'($urandom_range(0, 7)) : 3'b000);
      run_round($sformatf("rnd%0d", k), r1, r2, r3, $urandom_range(0, 6));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #50000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
